// File: rtl/queue_pkg.sv
// Shared defaults and width helpers for the parameterized queue.
package queue_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   // Pointer width indexes DEPTH entries; length needs one more bit to hold DEPTH itself.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int len_w(input int depth);
      return ptr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/param_queue_if.sv
// Request/status bundle between a queue user and param_queue.
interface param_queue_if #(
   parameter int DATA_W = queue_pkg::DEF_DATA_W,
   parameter int DEPTH  = queue_pkg::DEF_DEPTH
);
   localparam int LEN_W = queue_pkg::len_w(DEPTH);

   // enq_in/deq_in are requests sampled on every rising edge; there is no ready
   // signal, so the user learns acceptance from full/empty/len and the sticky
   // overflow/underflow flags. valid_out pulses for one cycle with each new data_out.
   logic              flush_in;
   logic [DATA_W-1:0] data_in;
   logic              enq_in;
   logic              deq_in;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic [LEN_W-1:0]  len_out;
   logic              full_out;
   logic              empty_out;
   logic              almost_full_out;
   logic              overflow_out;
   logic              underflow_out;

   modport master (
      output flush_in, data_in, enq_in, deq_in,
      input  data_out, valid_out, len_out, full_out, empty_out,
             almost_full_out, overflow_out, underflow_out
   );

   modport slave (
      input  flush_in, data_in, enq_in, deq_in,
      output data_out, valid_out, len_out, full_out, empty_out,
             almost_full_out, overflow_out, underflow_out
   );

endinterface

// File: rtl/queue_ptr.sv
// Wrap-around pointer counter; DEPTH is a power of two so natural overflow wraps.
module queue_ptr #(
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_value
);

   logic [PTR_W-1:0] r_value;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_value <= '0;
      end else if (i_inc) begin
         r_value <= r_value + PTR_W'(1);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/param_queue.sv
// Parameterized circular queue with registered read data, occupancy flags and
// sticky overflow/underflow error flags.
module param_queue
   import queue_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input logic          clock_10,
   input logic          reset,
   param_queue_if.slave bus
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int LEN_W = len_w(DEPTH);
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_AF   = LEN_W'(AF_LEVEL);

   logic [PTR_W-1:0]  w_head;
   logic [PTR_W-1:0]  w_tail;
   logic              w_deq_ok;
   logic              w_enq_ok;
   logic              w_deq_rej;
   logic              w_enq_rej;
   logic [LEN_W-1:0]  w_len_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic [LEN_W-1:0]  r_len;
   logic              r_full;
   logic              r_empty;
   logic              r_af;
   logic              r_ovf;
   logic              r_unf;

   // A dequeue frees a slot in the same cycle, so a full queue still accepts an enqueue
   // alongside it; an empty queue never passes data_in straight through.
   always_comb begin
      w_deq_ok  = bus.deq_in && (r_len != '0) && !bus.flush_in;
      w_enq_ok  = bus.enq_in && ((r_len != LEN_FULL) || w_deq_ok) && !bus.flush_in;
      w_deq_rej = bus.deq_in && !w_deq_ok && !bus.flush_in;
      w_enq_rej = bus.enq_in && !w_enq_ok && !bus.flush_in;
      w_len_nxt = r_len;
      if (bus.flush_in) begin
         w_len_nxt = '0;
      end else if (w_enq_ok && !w_deq_ok) begin
         w_len_nxt = r_len + LEN_W'(1);
      end else if (w_deq_ok && !w_enq_ok) begin
         w_len_nxt = r_len - LEN_W'(1);
      end
   end

   queue_ptr #(.PTR_W(PTR_W)) u_head (
      .clk     (clock_10),
      .rst     (reset),
      .i_clear (bus.flush_in),
      .i_inc   (w_deq_ok),
      .o_value (w_head)
   );

   queue_ptr #(.PTR_W(PTR_W)) u_tail (
      .clk     (clock_10),
      .rst     (reset),
      .i_clear (bus.flush_in),
      .i_inc   (w_enq_ok),
      .o_value (w_tail)
   );

   // Storage is deliberately left unreset; only entries between head and tail are ever read.
   always_ff @(posedge clock_10) begin
      if (!reset && w_enq_ok) begin
         r_mem[w_tail] <= bus.data_in;
      end
   end

   always_ff @(posedge clock_10) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_len   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_valid <= w_deq_ok;
         if (w_deq_ok) begin
            r_data <= r_mem[w_head];
         end
         r_len   <= w_len_nxt;
         r_full  <= (w_len_nxt == LEN_FULL);
         r_empty <= (w_len_nxt == '0);
         r_af    <= (w_len_nxt >= LEN_AF);
         if (bus.flush_in) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
         end else begin
            if (w_enq_rej) r_ovf <= 1'b1;
            if (w_deq_rej) r_unf <= 1'b1;
         end
      end
   end

   assign bus.data_out        = r_data;
   assign bus.valid_out       = r_valid;
   assign bus.len_out         = r_len;
   assign bus.full_out        = r_full;
   assign bus.empty_out       = r_empty;
   assign bus.almost_full_out = r_af;
   assign bus.overflow_out    = r_ovf;
   assign bus.underflow_out   = r_unf;

endmodule

// File: tb/tb_param_queue.sv
// Bench for param_queue: three configurations driven by one stimulus stream,
// each compared every cycle against its own queue model, plus directed checks.
module tb_param_queue;

   typedef struct packed {
      logic        rst;
      logic        flush;
      logic        enq;
      logic        deq;
      logic [15:0] data;
   } stim_t;

   logic clock_10 = 1'b0;
   logic reset    = 1'b1;
   always #5 clock_10 = ~clock_10;

   param_queue_if #(.DATA_W(8),  .DEPTH(8))  bus0 ();
   param_queue_if #(.DATA_W(16), .DEPTH(4))  bus1 ();
   param_queue_if #(.DATA_W(16), .DEPTH(16)) bus2 ();

   param_queue #(.DATA_W(8),  .DEPTH(8))  u_dut0 (.clock_10(clock_10), .reset(reset), .bus(bus0));
   param_queue #(.DATA_W(16), .DEPTH(4))  u_dut1 (.clock_10(clock_10), .reset(reset), .bus(bus1));
   param_queue #(.DATA_W(16), .DEPTH(16)) u_dut2 (.clock_10(clock_10), .reset(reset), .bus(bus2));

   int          depth_c [3] = '{8, 4, 16};
   int          af_c    [3] = '{6, 2, 14};
   logic [15:0] mask_c  [3] = '{16'h00FF, 16'hFFFF, 16'hFFFF};

   // Reference model: one element queue per configuration plus output/sticky state.
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   logic [15:0] mq2[$];
   logic [15:0] m_dout  [3];
   logic        m_valid [3];
   logic        m_ov    [3];
   logic        m_un    [3];

   logic [26:0] obs   [3];
   logic [26:0] exp_v [3];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   function automatic stim_t mk(input logic r, input logic f, input logic e,
                                input logic d, input logic [15:0] x);
      stim_t s;
      s.rst = r; s.flush = f; s.enq = e; s.deq = d; s.data = x;
      return s;
   endfunction

   function automatic int q_size(input int k);
      case (k)
         0:       return mq0.size();
         1:       return mq1.size();
         default: return mq2.size();
      endcase
   endfunction

   task automatic model_step(input int k, input stim_t s);
      logic [15:0] q[$];
      bit dok;
      bit eok;
      case (k)
         0:       q = mq0;
         1:       q = mq1;
         default: q = mq2;
      endcase
      if (s.rst) begin
         q.delete();
         m_dout[k] = '0; m_valid[k] = 1'b0; m_ov[k] = 1'b0; m_un[k] = 1'b0;
      end else if (s.flush) begin
         q.delete();
         m_valid[k] = 1'b0; m_ov[k] = 1'b0; m_un[k] = 1'b0;
      end else begin
         dok = s.deq && (q.size() > 0);
         eok = s.enq && ((q.size() < depth_c[k]) || dok);
         m_valid[k] = dok;
         if (dok) m_dout[k] = q.pop_front();
         if (s.deq && !dok) m_un[k] = 1'b1;
         if (s.enq && !eok) m_ov[k] = 1'b1;
         if (eok) q.push_back(s.data & mask_c[k]);
      end
      case (k)
         0:       mq0 = q;
         1:       mq1 = q;
         default: mq2 = q;
      endcase
   endtask

   function automatic logic [26:0] exp_pack(input int k);
      int n;
      n = q_size(k);
      return {m_dout[k], m_valid[k], 5'(n), (n == depth_c[k]), (n == 0),
              (n >= af_c[k]), m_ov[k], m_un[k]};
   endfunction

   task automatic drive(input stim_t s);
      reset         = s.rst;
      bus0.flush_in = s.flush; bus0.enq_in = s.enq; bus0.deq_in = s.deq; bus0.data_in = s.data[7:0];
      bus1.flush_in = s.flush; bus1.enq_in = s.enq; bus1.deq_in = s.deq; bus1.data_in = s.data;
      bus2.flush_in = s.flush; bus2.enq_in = s.enq; bus2.deq_in = s.deq; bus2.data_in = s.data;
   endtask

   // One clock: drive, advance the models at the edge, sample #1 later.
   task automatic step(input stim_t s);
      drive(s);
      @(posedge clock_10);
      for (int k = 0; k < 3; k++) model_step(k, s);
      #1;
      obs[0] = {8'h00, bus0.data_out, bus0.valid_out, 1'b0, bus0.len_out, bus0.full_out,
                bus0.empty_out, bus0.almost_full_out, bus0.overflow_out, bus0.underflow_out};
      obs[1] = {bus1.data_out, bus1.valid_out, 2'b00, bus1.len_out, bus1.full_out,
                bus1.empty_out, bus1.almost_full_out, bus1.overflow_out, bus1.underflow_out};
      obs[2] = {bus2.data_out, bus2.valid_out, bus2.len_out, bus2.full_out,
                bus2.empty_out, bus2.almost_full_out, bus2.overflow_out, bus2.underflow_out};
      for (int k = 0; k < 3; k++) exp_v[k] = exp_pack(k);
      cyc++;
   endtask

   task automatic test_reset();
      stim_t s[$];
      s.push_back(mk(1, 0, 0, 0, 16'h0000));
      s.push_back(mk(1, 1, 1, 1, 16'h1234));
      foreach (s[i]) begin
         step(s[i]);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL reset_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
         n_checks++;
         if (obs[0] !== {16'h0000, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000})
            $display("FAIL reset_values cyc %0d: got %h expected %h", cyc, obs[0], {16'h0000, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000});
         else n_pass++;
      end
   endtask

   task automatic test_fill();
      stim_t s[$];
      s.push_back(mk(0, 1, 0, 0, 16'h0000));
      for (int i = 1; i <= 8; i++) s.push_back(mk(0, 0, 1, 0, 16'(32'h11 * i)));
      s.push_back(mk(0, 0, 1, 0, 16'h0099));
      foreach (s[i]) begin
         step(s[i]);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL fill_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
         if (i >= 1 && i <= 8) begin
            n_checks++;
            if ({bus0.len_out, bus0.full_out, bus0.almost_full_out, bus0.overflow_out} !== {4'(i), (i == 8), (i >= 6), 1'b0})
               $display("FAIL fill_flags step %0d: got %h expected %h", i,
                        {bus0.len_out, bus0.full_out, bus0.almost_full_out, bus0.overflow_out}, {4'(i), (i == 8), (i >= 6), 1'b0});
            else n_pass++;
         end else if (i == 9) begin
            n_checks++;
            if ({bus0.len_out, bus0.full_out, bus0.overflow_out} !== {4'd8, 1'b1, 1'b1})
               $display("FAIL fill_overflow: got %h expected %h", {bus0.len_out, bus0.full_out, bus0.overflow_out}, {4'd8, 1'b1, 1'b1});
            else n_pass++;
         end
      end
   endtask

   task automatic test_drain();
      stim_t s[$];
      for (int i = 0; i < 9; i++) s.push_back(mk(0, 0, 0, 1, 16'h0000));
      s.push_back(mk(0, 0, 0, 0, 16'h0000));
      foreach (s[i]) begin
         step(s[i]);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL drain_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
         n_checks++;
         if (i < 8) begin
            if ({bus0.valid_out, bus0.data_out} !== {1'b1, 8'(32'h11 * (i + 1))})
               $display("FAIL drain_data step %0d: got %h expected %h", i, {bus0.valid_out, bus0.data_out}, {1'b1, 8'(32'h11 * (i + 1))});
            else n_pass++;
         end else begin
            if ({bus0.valid_out, bus0.data_out, bus0.underflow_out, bus0.empty_out} !== {1'b0, 8'h88, 1'b1, 1'b1})
               $display("FAIL drain_underflow step %0d: got %h expected %h", i,
                        {bus0.valid_out, bus0.data_out, bus0.underflow_out, bus0.empty_out}, {1'b0, 8'h88, 1'b1, 1'b1});
            else n_pass++;
         end
      end
   endtask

   task automatic test_wrap();
      stim_t s[$];
      s.push_back(mk(0, 1, 0, 0, 16'h0000));
      for (int i = 0; i < 5; i++) s.push_back(mk(0, 0, 1, 0, 16'($urandom)));
      for (int i = 0; i < 5; i++) s.push_back(mk(0, 0, 0, 1, 16'h0000));
      for (int i = 0; i < 8; i++) s.push_back(mk(0, 0, 1, 0, 16'(32'hA0 + i)));
      for (int i = 0; i < 8; i++) s.push_back(mk(0, 0, 0, 1, 16'h0000));
      foreach (s[i]) begin
         step(s[i]);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL wrap_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
         if (i >= 19) begin
            n_checks++;
            if ({bus0.valid_out, bus0.data_out, bus0.overflow_out} !== {1'b1, 8'(32'hA0 + i - 19), 1'b0})
               $display("FAIL wrap_data step %0d: got %h expected %h", i,
                        {bus0.valid_out, bus0.data_out, bus0.overflow_out}, {1'b1, 8'(32'hA0 + i - 19), 1'b0});
            else n_pass++;
         end
      end
   endtask

   task automatic test_simultaneous();
      stim_t s[$];
      logic [15:0] first;
      first = 16'($urandom);
      s.push_back(mk(0, 1, 0, 0, 16'h0000));
      s.push_back(mk(0, 0, 1, 0, first));
      for (int i = 1; i < 8; i++) s.push_back(mk(0, 0, 1, 0, 16'($urandom)));
      s.push_back(mk(0, 0, 1, 1, 16'h00FF));
      s.push_back(mk(0, 1, 0, 0, 16'h0000));
      s.push_back(mk(0, 0, 1, 1, 16'h0042));
      s.push_back(mk(0, 0, 0, 1, 16'h0000));
      foreach (s[i]) begin
         step(s[i]);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL simul_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
         if (i == 9) begin
            n_checks++;
            if ({bus0.valid_out, bus0.data_out, bus0.len_out, bus0.overflow_out} !== {1'b1, first[7:0], 4'd8, 1'b0})
               $display("FAIL simul_full: got %h expected %h", {bus0.valid_out, bus0.data_out, bus0.len_out, bus0.overflow_out},
                        {1'b1, first[7:0], 4'd8, 1'b0});
            else n_pass++;
         end else if (i == 11) begin
            n_checks++;
            if ({bus0.valid_out, bus0.len_out, bus0.underflow_out} !== {1'b0, 4'd1, 1'b1})
               $display("FAIL simul_empty: got %h expected %h", {bus0.valid_out, bus0.len_out, bus0.underflow_out}, {1'b0, 4'd1, 1'b1});
            else n_pass++;
         end else if (i == 12) begin
            n_checks++;
            if ({bus0.valid_out, bus0.data_out, bus0.len_out} !== {1'b1, 8'h42, 4'd0})
               $display("FAIL simul_passdata: got %h expected %h", {bus0.valid_out, bus0.data_out, bus0.len_out}, {1'b1, 8'h42, 4'd0});
            else n_pass++;
         end
      end
   endtask

   task automatic test_flush_reset();
      stim_t s[$];
      s.push_back(mk(0, 1, 0, 0, 16'h0000));
      for (int i = 0; i < 9; i++) s.push_back(mk(0, 0, 1, 0, 16'($urandom)));
      for (int i = 0; i < 4; i++) s.push_back(mk(0, 0, 0, 1, 16'h0000));
      s.push_back(mk(0, 1, 1, 0, 16'h0055));
      for (int i = 0; i < 3; i++) s.push_back(mk(0, 0, 1, 0, 16'($urandom)));
      s.push_back(mk(1, 0, 1, 1, 16'h0066));
      s.push_back(mk(0, 0, 1, 0, 16'h0077));
      s.push_back(mk(0, 0, 0, 1, 16'h0000));
      foreach (s[i]) begin
         step(s[i]);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL flush_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
         if (i == 13) begin
            n_checks++;
            if ({bus0.len_out, bus0.overflow_out} !== {4'd4, 1'b1})
               $display("FAIL flush_setup: got %h expected %h", {bus0.len_out, bus0.overflow_out}, {4'd4, 1'b1});
            else n_pass++;
         end else if (i == 14) begin
            n_checks++;
            if (obs[0][10:0] !== {1'b0, 5'd0, 1'b0, 1'b1, 3'b000})
               $display("FAIL flush_clear: got %h expected %h", obs[0][10:0], {1'b0, 5'd0, 1'b0, 1'b1, 3'b000});
            else n_pass++;
         end else if (i == 18) begin
            n_checks++;
            if (obs[0] !== {16'h0000, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000})
               $display("FAIL midstream_reset: got %h expected %h", obs[0], {16'h0000, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000});
            else n_pass++;
         end else if (i == 20) begin
            n_checks++;
            if ({bus0.valid_out, bus0.data_out} !== {1'b1, 8'h77})
               $display("FAIL post_reset_data: got %h expected %h", {bus0.valid_out, bus0.data_out}, {1'b1, 8'h77});
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      stim_t s;
      bit fill_phase;
      for (int i = 0; i < 400; i++) begin
         fill_phase = ((i / 40) % 2) == 0;
         s = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                fill_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
                fill_phase ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
                16'($urandom));
         step(s);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_v[k]) $display("FAIL random_model dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp_v[k]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      drive(mk(1, 0, 0, 0, 16'h0000));
      for (int k = 0; k < 3; k++) begin
         m_dout[k] = '0; m_valid[k] = 1'b0; m_ov[k] = 1'b0; m_un[k] = 1'b0;
      end
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_flush_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored element.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two, at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: occupancy at or above which almost_full_out asserts.
REQ-004 Port: clock_10  input  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: flush_in  input  1  synchronous clear of contents and flags.
REQ-007 Port: data_in  input  DATA_W  element to enqueue.
REQ-008 Port: enq_in  input  1  enqueue request, sampled each cycle.
REQ-009 Port: deq_in  input  1  dequeue request, sampled each cycle.
REQ-010 Port: data_out  output  DATA_W  last dequeued element, registered.
REQ-011 Port: valid_out  output  1  one-cycle pulse: data_out updated this cycle.
REQ-012 Port: len_out  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 Port: full_out / empty_out / almost_full_out  output  1 each  occupancy flags.
REQ-014 Port: overflow_out / underflow_out  output  1 each  sticky error flags.

Function
REQ-015 Enqueue SHALL be accepted when enq_in=1 and (len_out<DEPTH or a dequeue is accepted in the same cycle); data_in is written at the tail and the tail pointer advances.
REQ-016 Dequeue SHALL be accepted when deq_in=1 and len_out>0; the head entry is registered onto data_out, valid_out=1 next cycle, and the head pointer advances.
REQ-017 Dequeue latency SHALL be exactly 1 cycle from the sampling edge to data_out/valid_out.
REQ-018 data_out SHALL hold its value when no dequeue is accepted; valid_out SHALL be 0 in that case.
REQ-019 Pointers SHALL wrap modulo DEPTH with no skipped or duplicated entry.
REQ-020 len_out SHALL be: +1 on accepted enqueue only, -1 on accepted dequeue only, unchanged on both or neither.
REQ-021 Full with enq+deq: both SHALL be accepted, len_out stays DEPTH, and the oldest entry is output.
REQ-022 Empty with enq+deq: enqueue SHALL be accepted, dequeue rejected (no pass-through), and underflow_out set.
REQ-023 Rejected enqueue (full, no dequeue) SHALL set overflow_out, leave the contents unmodified, and drop data_in.
REQ-024 Rejected dequeue SHALL set underflow_out and leave data_out unchanged.
REQ-025 overflow_out/underflow_out SHALL stay 1 until reset or flush_in.
REQ-026 Flags SHALL be registered and consistent with len_out in the same cycle: full_out=(len_out==DEPTH), empty_out=(len_out==0), almost_full_out=(len_out>=AF_LEVEL).
REQ-027 flush_in SHALL take priority over enq_in/deq_in: it zeroes the pointers, len_out and sticky flags, sets valid_out=0, holds data_out, and accepts no request that cycle.

Reset
REQ-028 reset SHALL be sampled only on the clock_10 rising edge and SHALL override flush_in, enq_in and deq_in.
REQ-029 Reset values: data_out=0, valid_out=0, len_out=0, empty_out=1, full_out=0, almost_full_out=0, overflow_out=0, underflow_out=0, both pointers 0.
REQ-030 Storage array contents SHALL NOT require reset; no output may depend on unwritten entries.
REQ-031 Reset asserted mid-stream SHALL discard all contents; the first dequeue after release returns the first post-reset enqueue.

Structure
REQ-032 Package queue_pkg SHALL hold the default DATA_W/DEPTH constants and a function computing the pointer and length widths.
REQ-033 One sub-module, queue_ptr, SHALL implement a wrap-around pointer counter (inc, clear, value) instantiated for head and tail.
REQ-034 Storage SHALL be a single DEPTH x DATA_W register array with one write port and one read port; no simulation-only display calls in synthesizable code.

Verification
REQ-035 Fill to capacity (defaults): enqueue 0x11..0x88 -> len_out=8, full_out=1, almost_full_out=1 from len 6; a 9th enqueue 0x99 sets overflow_out=1 and the contents stay unchanged.
REQ-036 Drain: 8 dequeues -> data_out 0x11..0x88 in order, each valid_out one cycle after its request; a 9th dequeue sets underflow_out=1 and data_out stays 0x88.
REQ-037 Wrap-around: 5 enq, 5 deq, then 8 enq 0xA0..0xA7 and 8 deq -> output 0xA0..0xA7 in order, with no overflow.
REQ-038 Simultaneous at full: with len 8, enq 0xFF and deq in one cycle -> output is the oldest entry, len stays 8; at empty: enq 0x42 and deq -> len 1, underflow_out=1, 0x42 returned by the next deq.
REQ-039 Flush/reset: with len 4 and overflow_out=1, assert flush_in together with enq_in -> len 0, empty_out=1, flags 0; repeat with reset mid-stream -> all REQ-029 values the next cycle.
REQ-040 Parameter sweep: DATA_W=16, DEPTH=4 and DEPTH=16 rerun REQ-035..REQ-038 with a scoreboard model.
